// File: rtl/memory_arbiter_pkg.sv
// Shared defines for the two-port memory arbiter: data width, state encoding, default latency.
// MEMORY_WIDTH may be overridden on the command line; ARBITER_RR_EN selects round-robin arbitration.
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 32
`endif

package memory_arbiter_pkg;

  localparam int unsigned MEM_WIDTH_DEF = `MEMORY_WIDTH;
  localparam int unsigned LATENCY_DEF   = 4;
  // Counter wide enough for the largest legal latency (15).
  localparam int unsigned CNT_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of the instruction-side, data-side and shared-memory signals around the arbiter.
// slave is the arbiter's view; master is the requesters' and memory's view.
interface memory_arbiter_if #(
  parameter int unsigned WIDTH = `MEMORY_WIDTH,
  parameter int unsigned ADDR  = 32
);

  logic             ic_req;
  logic [ADDR-1:0]  ic_addr;
  logic [WIDTH-1:0] ic_rdata;
  logic             ic_ack;

  logic             dc_req;
  logic             dc_write;
  logic [ADDR-1:0]  dc_addr;
  logic [WIDTH-1:0] dc_wdata;
  logic [WIDTH-1:0] dc_rdata;
  logic             dc_ack;

  logic [ADDR-1:0]  mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_read;
  logic             mem_write;
  logic [WIDTH-1:0] mem_rdata;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_write, dc_addr, dc_wdata, mem_rdata,
    output ic_rdata, ic_ack, dc_rdata, dc_ack, mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_write, dc_addr, dc_wdata, mem_rdata,
    input  ic_rdata, ic_ack, dc_rdata, dc_ack, mem_addr, mem_wdata, mem_read, mem_write
  );

endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates instruction and data requesters onto one fixed-latency memory, one transaction at a time.
// Define ARBITER_RR_EN for round-robin contention; otherwise the data side always wins.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH   = `MEMORY_WIDTH,
  parameter int unsigned ADDR    = 32,
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input  logic            clk,
  input  logic            reset,
  memory_arbiter_if.slave bus
);

  localparam bit LAT_ONE = (LATENCY == 32'd1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt_dc_q, gnt_dc_d;
  logic             wr_q, wr_d;
  logic [ADDR-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] ic_rdata_q, ic_rdata_d;
  logic [WIDTH-1:0] dc_rdata_q, dc_rdata_d;
  logic             ic_ack_q, ic_ack_d;
  logic             dc_ack_q, dc_ack_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;

  logic             req_any_c;
  logic             pick_dc_c;

  assign req_any_c = bus.ic_req | bus.dc_req;

`ifdef ARBITER_RR_EN
  // Remembers which side won the most recent grant; reset means "instruction side".
  logic last_dc_q, last_dc_d;

  assign pick_dc_c = bus.dc_req & (~bus.ic_req | ~last_dc_q);

  always_comb begin
    last_dc_d = last_dc_q;
    if (state_q == ST_IDLE && req_any_c) begin
      last_dc_d = pick_dc_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_dc_q <= 1'b0;
    end else begin
      last_dc_q <= last_dc_d;
    end
  end
`else
  assign pick_dc_c = bus.dc_req;
`endif

  // Next-state and registered-output logic; inputs are only looked at in IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_dc_d    = gnt_dc_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ic_rdata_d  = ic_rdata_q;
    dc_rdata_d  = dc_rdata_q;
    ic_ack_d    = 1'b0;
    dc_ack_d    = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_any_c) begin
          state_d  = ST_BUSY;
          cnt_d    = CNT_W'(LATENCY - 32'd1);
          gnt_dc_d = pick_dc_c;
          wr_d     = pick_dc_c & bus.dc_write;
          addr_d   = pick_dc_c ? bus.dc_addr : bus.ic_addr;
          if (pick_dc_c) begin
            wdata_d = bus.dc_wdata;
          end
          mem_read_d  = ~wr_d;
          mem_write_d = wr_d & LAT_ONE;
        end
      end

      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d  = ST_DONE;
          ic_ack_d = ~gnt_dc_q;
          dc_ack_d = gnt_dc_q;
          if (!wr_q) begin
            if (gnt_dc_q) begin
              dc_rdata_d = bus.mem_rdata;
            end else begin
              ic_rdata_d = bus.mem_rdata;
            end
          end
        end else begin
          cnt_d       = cnt_q - CNT_W'(1);
          mem_read_d  = ~wr_q;
          // The single write strobe lands on the last busy cycle.
          mem_write_d = wr_q & (cnt_q == CNT_W'(1));
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      gnt_dc_q    <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
      ic_ack_q    <= 1'b0;
      dc_ack_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_dc_q    <= gnt_dc_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ic_rdata_q  <= ic_rdata_d;
      dc_rdata_q  <= dc_rdata_d;
      ic_ack_q    <= ic_ack_d;
      dc_ack_q    <= dc_ack_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign bus.ic_rdata  = ic_rdata_q;
  assign bus.ic_ack    = ic_ack_q;
  assign bus.dc_rdata  = dc_rdata_q;
  assign bus.dc_ack    = dc_ack_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Testbench for memory_arbiter: directed scenarios then random traffic against a transaction-timeline model.
// The model tracks one transaction as (start cycle, side, direction, address) and derives every strobe from it.
module tb_memory_arbiter;

  localparam int W = 32;
  localparam int A = 32;
  localparam int L = 4;

  logic clk = 1'b0;
  logic reset;

  memory_arbiter_if #(.WIDTH(W), .ADDR(A)) bus ();

  memory_arbiter #(.WIDTH(W), .ADDR(A), .LATENCY(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Shared memory: combinational read, write on the strobe.
  logic [W-1:0] mem_arr [64];
  assign bus.mem_rdata = mem_arr[bus.mem_addr[7:2]];
  always @(posedge clk) begin
    if (bus.mem_write) mem_arr[bus.mem_addr[7:2]] <= bus.mem_wdata;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state.
  logic [W-1:0] ref_mem [64];
  bit           t_act = 1'b0;
  int           t_s;
  bit           t_dc, t_wr;
  logic [A-1:0] t_addr;
  logic [W-1:0] t_wdata;
  logic [W-1:0] e_ic_rd, e_dc_rd, e_wdata;
  logic [A-1:0] e_addr;
  bit           wd_known;
  bit           m_last_dc;
  bit           e_ic_ack, e_dc_ack, e_rd, e_wr;

  // Stimulus state.
  logic         drv_ic_req = 1'b0, drv_dc_req = 1'b0, drv_dc_wr = 1'b0;
  logic [A-1:0] drv_ic_addr = '0, drv_dc_addr = '0;
  logic [W-1:0] drv_dc_wdata = '0;
  bit           chk_en = 1'b0, auto_rel = 1'b1, rand_mode = 1'b0;
  bit           ic_pend = 1'b0, dc_pend = 1'b0, ic_drop = 1'b0, dc_drop = 1'b0;
  int           n_rd_obs = 0, n_wr_obs = 0, n_ic_obs = 0, n_dc_obs = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sample_check();
    @(negedge clk);
    e_ic_ack = t_act && !t_dc && (cyc == t_s + L + 1);
    e_dc_ack = t_act &&  t_dc && (cyc == t_s + L + 1);
    e_rd     = t_act && !t_wr && (cyc > t_s) && (cyc <= t_s + L);
    e_wr     = t_act &&  t_wr && (cyc == t_s + L);
    if (chk_en) begin
      check("ic_ack",    64'(bus.ic_ack),    64'(e_ic_ack));
      check("dc_ack",    64'(bus.dc_ack),    64'(e_dc_ack));
      check("mem_read",  64'(bus.mem_read),  64'(e_rd));
      check("mem_write", 64'(bus.mem_write), 64'(e_wr));
      check("mem_addr",  64'(bus.mem_addr),  64'(e_addr));
      if (wd_known) check("mem_wdata", 64'(bus.mem_wdata), 64'(e_wdata));
      check("ic_rdata",  64'(bus.ic_rdata),  64'(e_ic_rd));
      check("dc_rdata",  64'(bus.dc_rdata),  64'(e_dc_rd));
      if (bus.mem_read)  n_rd_obs++;
      if (bus.mem_write) n_wr_obs++;
      if (bus.ic_ack)    n_ic_obs++;
      if (bus.dc_ack)    n_dc_obs++;
    end
  endtask

  // Advances the model across the clock edge that ends the current cycle.
  task automatic model_edge(input bit rst_v);
    bit pick;
    if (rst_v) begin
      t_act = 1'b0; e_ic_rd = '0; e_dc_rd = '0; e_addr = '0; e_wdata = '0;
      wd_known = 1'b1; m_last_dc = 1'b0;
      return;
    end
    if (t_act && cyc == t_s + L) begin
      if (t_wr)      ref_mem[t_addr[7:2]] = t_wdata;
      else if (t_dc) e_dc_rd = ref_mem[t_addr[7:2]];
      else           e_ic_rd = ref_mem[t_addr[7:2]];
    end
    if ((!t_act || cyc >= t_s + L + 2) && (drv_ic_req || drv_dc_req)) begin
`ifdef ARBITER_RR_EN
      pick = drv_dc_req && (!drv_ic_req || !m_last_dc);
`else
      pick = drv_dc_req;
`endif
      t_act   = 1'b1;
      t_s     = cyc;
      t_dc    = pick;
      t_wr    = pick && drv_dc_wr;
      t_addr  = pick ? drv_dc_addr : drv_ic_addr;
      t_wdata = drv_dc_wdata;
      e_addr  = t_addr;
      if (pick) begin e_wdata = drv_dc_wdata; wd_known = 1'b1; end
      else      wd_known = 1'b0;
      m_last_dc = pick;
    end
  endtask

  task automatic randomize_drivers(input bit rst_v);
    bit busy_now;
    if (e_ic_ack || rst_v) begin ic_pend = 1'b0; ic_drop = 1'b0; end
    if (e_dc_ack || rst_v) begin dc_pend = 1'b0; dc_drop = 1'b0; end
    if (!ic_pend && $urandom_range(3) == 0) begin
      ic_pend = 1'b1;
      drv_ic_addr = A'($urandom_range(255));
    end
    if (!dc_pend && $urandom_range(3) == 0) begin
      dc_pend      = 1'b1;
      drv_dc_wr    = 1'($urandom_range(1));
      drv_dc_addr  = A'($urandom_range(255));
      drv_dc_wdata = W'($urandom);
    end
    busy_now = t_act && (cyc > t_s) && (cyc <= t_s + L);
    if (busy_now && $urandom_range(7) == 0) begin
      if (t_dc) dc_drop = 1'b1;
      else      ic_drop = 1'b1;
    end
    drv_ic_req = ic_pend && !ic_drop && !rst_v;
    drv_dc_req = dc_pend && !dc_drop && !rst_v;
  endtask

  task automatic tick(input bit rst_v);
    sample_check();
    if (auto_rel) begin
      if (e_ic_ack) drv_ic_req = 1'b0;
      if (e_dc_ack) drv_dc_req = 1'b0;
    end
    if (rand_mode) randomize_drivers(rst_v);
    bus.ic_req   = drv_ic_req;
    bus.ic_addr  = drv_ic_addr;
    bus.dc_req   = drv_dc_req;
    bus.dc_write = drv_dc_wr;
    bus.dc_addr  = drv_dc_addr;
    bus.dc_wdata = drv_dc_wdata;
    reset        = rst_v;
    model_edge(rst_v);
    cyc++;
  endtask

  task automatic clear_obs();
    n_rd_obs = 0; n_wr_obs = 0; n_ic_obs = 0; n_dc_obs = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      logic [W-1:0] v;
      v = W'($urandom);
      mem_arr[i] = v;
      ref_mem[i] = v;
    end
    mem_arr[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    reset = 1'b1;
    bus.ic_req = 1'b0; bus.ic_addr = '0; bus.dc_req = 1'b0; bus.dc_write = 1'b0;
    bus.dc_addr = '0; bus.dc_wdata = '0;

    // Reset, then idle cycles check all-zero outputs.
    tick(1'b1);
    chk_en = 1'b1;
    tick(1'b1);
    repeat (2) tick(1'b0);

    // Instruction read of 0x10.
    clear_obs();
    drv_ic_addr = 32'h10; drv_ic_req = 1'b1;
    repeat (L + 4) tick(1'b0);
    check("t1_rd_cycles", 64'(n_rd_obs), 64'(L));
    check("t1_ic_acks",   64'(n_ic_obs), 64'd1);
    check("t1_dc_acks",   64'(n_dc_obs), 64'd0);
    check("t1_ic_rdata",  64'(bus.ic_rdata), 64'h0000_0000_DEAD_BEEF);

    // Data write of 0x12345678 to 0x20.
    clear_obs();
    drv_dc_wr = 1'b1; drv_dc_addr = 32'h20; drv_dc_wdata = 32'h12345678; drv_dc_req = 1'b1;
    repeat (L + 4) tick(1'b0);
    check("t2_wr_cycles", 64'(n_wr_obs), 64'd1);
    check("t2_rd_cycles", 64'(n_rd_obs), 64'd0);
    check("t2_dc_acks",   64'(n_dc_obs), 64'd1);
    check("t2_mem_word",  64'(mem_arr[8]), 64'h0000_0000_1234_5678);

    // Both sides held high from a fresh reset.
    tick(1'b1);
    clear_obs();
    auto_rel = 1'b0;
    drv_dc_wr = 1'b0; drv_dc_addr = 32'h20; drv_ic_addr = 32'h10;
    drv_ic_req = 1'b1; drv_dc_req = 1'b1;
    repeat (4 * (L + 2)) tick(1'b0);
`ifdef ARBITER_RR_EN
    check("t3_ic_grants", 64'(n_ic_obs), 64'd2);
    check("t3_dc_grants", 64'(n_dc_obs), 64'd2);
`else
    check("t3_ic_grants", 64'(n_ic_obs), 64'd0);
    check("t3_dc_grants", 64'(n_dc_obs), 64'd4);
`endif
    drv_ic_req = 1'b0; drv_dc_req = 1'b0; auto_rel = 1'b1;
    repeat (L + 4) tick(1'b0);

    // Reset on the second busy cycle of a write aborts it.
    clear_obs();
    drv_dc_wr = 1'b1; drv_dc_addr = 32'h24; drv_dc_wdata = 32'hA5A5_5A5A; drv_dc_req = 1'b1;
    tick(1'b0);
    tick(1'b0);
    drv_dc_req = 1'b0;
    tick(1'b1);
    repeat (L + 3) tick(1'b0);
    check("t4_wr_cycles", 64'(n_wr_obs), 64'd0);
    check("t4_dc_acks",   64'(n_dc_obs), 64'd0);
    check("t4_mem_word",  64'(mem_arr[9]), 64'(ref_mem[9]));

    // Data read dropped on its first busy cycle still completes.
    clear_obs();
    drv_dc_wr = 1'b0; drv_dc_addr = 32'h10; drv_dc_req = 1'b1;
    tick(1'b0);
    drv_dc_req = 1'b0;
    repeat (L + 3) tick(1'b0);
    check("t5_dc_acks",  64'(n_dc_obs), 64'd1);
    check("t5_dc_rdata", 64'(bus.dc_rdata), 64'h0000_0000_DEAD_BEEF);

    // Random traffic with occasional drops and resets.
    rand_mode = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      tick(1'($urandom_range(149) == 0));
    end
    rand_mode = 1'b0;
    drv_ic_req = 1'b0; drv_dc_req = 1'b0;
    repeat (L + 4) tick(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
